linebuffer_window: RTL
======================

Name: linebuffer_window

Overview:
- Streaming line buffer that turns a raster-order pixel stream into a sliding 8-row x 10-column window of 7-bit pixels.
- Presents the window as the 81-entry array consumed by the downstream inner-product stages: entry 0 is the bias slot, entries 1..80 are pixels.
- Sits directly upstream of the innerproductNN bank; one window per accepted pixel once the window lies fully inside the frame.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- WIN_W, 10, window width (columns)
- WIN_H, 8, window height (rows); WIN_W*WIN_H must equal 80
- PIX_W, 7, pixel width in bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- sof  in  1  start of frame; qualifies the pixel on the same cycle as pixel (0,0)
- pix_valid  in  1  pixel strobe; no backpressure, gaps allowed
- pix_in  in  PIX_W  pixel value
- xarray  out  [0:80] x PIX_W  window; xarray[0]=0 always, xarray[1+r*WIN_W+c] = pixel at window row r (0=top/oldest), column c (0=left/oldest)
- win_valid  out  1  one-cycle pulse: xarray holds a new complete window
- win_x  out  5  column of window top-left pixel in image
- win_y  out  5  row of window top-left pixel in image
- frame_done  out  1  one-cycle pulse after last pixel (IMG_H-1, IMG_W-1) accepted
- overflow  out  1  sticky: pixel received after frame complete or before first sof

Behaviour:
- Reset (async): all outputs 0, xarray all 0, counters col=row=0, state IDLE; line RAM contents don't-care.
- States: IDLE (await sof), FILL (accepting pixels), DONE (frame complete, await sof).
- IDLE: pix_valid without sof -> pixel dropped, overflow set. sof&pix_valid -> pixel taken as (0,0), go FILL.
- sof without pix_valid: no effect (sof must accompany the first pixel).
- FILL, accepted pixel (pix_valid=1): write pix_in to line RAM column col; shift window register left one column, new column = WIN_H-1 line RAM outputs at col (oldest row at top) plus pix_in at bottom; col++, wrap to 0 at IMG_W-1 with row++.
- Accepted pixel at (IMG_H-1, IMG_W-1): go DONE, frame_done=1 next cycle.
- Window output valid condition for accepted pixel at (row,col): row>=WIN_H-1 and col>=WIN_W-1; then next cycle win_valid=1, xarray updated, win_x=col-(WIN_W-1), win_y=row-(WIN_H-1). Windows never straddle a row wrap.
- Latency: exactly 1 cycle from accepted pixel to win_valid. xarray holds last value when win_valid=0.
- Window count per frame: (IMG_H-WIN_H+1)*(IMG_W-WIN_W+1) = 399 at defaults.
- pix_valid=0 cycles: no state change, win_valid=0.
- sof&pix_valid in FILL or DONE: restart; pixel is (0,0) of new frame, counters reset, no window emitted from stale rows (row counter gates validity). overflow unaffected.
- DONE: pix_valid without sof -> dropped, overflow set.
- Line RAM: WIN_H-1 lines of IMG_W x PIX_W, read-before-write at address col, implemented as a cascade: line k output feeds line k+1 input.
- Reset mid-frame: immediate return to IDLE; next frame must begin with sof.

Decomposition:
- Package lb_pkg: PIX_W, WIN_W, WIN_H, NTAP=81, pixel_t (logic [PIX_W-1:0]), state enum {IDLE,FILL,DONE}.
- Sub-module line_delay: one IMG_W-deep circular line store, read-before-write at shared col pointer; instantiated WIN_H-1 times in a cascade.

Test Plan:
- 28x28 frame, pixel(r,c)=(r*28+c)%128, continuous valid -> first win_valid 1 cycle after pixel (7,9); xarray[0]=0, xarray[1]=0, xarray[80]=77, win_x=0, win_y=0; 399 win_valid pulses; frame_done once after (27,27).
- Same frame with random pix_valid gaps (~50%) -> identical xarray/win_x/win_y sequence as continuous run; win_valid only on cycles following accepted pixels.
- Last window check -> win_x=18, win_y=20, xarray[1]=pixel(20,18)=(578%128)=66, xarray[80]=pixel(27,27)=(783%128)=15.
- sof re-asserted at pixel (10,5) of frame 1, then full frame 2 -> no window from frame-1 rows; frame 2 yields 399 windows; overflow stays 0.
- pix_valid before any sof, and extra pixel after frame_done -> overflow=1 and stays 1; no win_valid.
- rst asserted mid-frame (row 12) -> outputs 0 asynchronously; subsequent sof-started frame behaves as scenario 1.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared types and window geometry for the line-buffer window generator.
package lb_pkg;
  localparam int PIX_W = 7;
  localparam int WIN_W = 10;
  localparam int WIN_H = 8;
  localparam int NTAP  = WIN_W*WIN_H + 1;
  localparam int CRD_W = 5;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [0:NTAP-1] xarray_t;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
endpackage

// File: rtl/linebuffer_window_if.sv
// Pixel stream in, window array out; master is the pixel source.
interface linebuffer_window_if;
  import lb_pkg::*;

  logic              sof;
  logic              pix_valid;
  pixel_t            pix_in;
  xarray_t           xarray;
  logic              win_valid;
  logic [CRD_W-1:0]  win_x;
  logic [CRD_W-1:0]  win_y;
  logic              frame_done;
  logic              overflow;

  modport master (
    output sof, pix_valid, pix_in,
    input  xarray, win_valid, win_x, win_y, frame_done, overflow
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output xarray, win_valid, win_x, win_y, frame_done, overflow
  );
endinterface

// File: rtl/line_delay.sv
// One image line of delay: circular store, read-before-write at the shared column pointer.
module line_delay
  import lb_pkg::*;
#(
  parameter int IMG_W = 28,
  localparam int AW   = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] col,
  input  pixel_t        din,
  output pixel_t        dout
);
  pixel_t mem [IMG_W];

  assign dout = mem[col];

  always_ff @(posedge clk)
    if (en) mem[col] <= din;
endmodule

// File: rtl/linebuffer_window.sv
// Raster stream -> sliding WIN_H x WIN_W window, emitted as the 81-tap array (tap 0 = bias slot).
module linebuffer_window
  import lb_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input logic                 clk,
  input logic                 rst,
  linebuffer_window_if.slave  lb
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
  localparam logic [CW-1:0] COL_V    = CW'(WIN_W-1);
  localparam logic [RW-1:0] ROW_V    = RW'(WIN_H-1);

  state_t        state, state_nxt;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          restart, accept, drop, last_pix, win_hit;

  pixel_t                          lout [WIN_H-1];
  pixel_t [0:WIN_H-1]              newcol;
  pixel_t [0:WIN_H-1][0:WIN_W-1]   win_q, win_nxt;
  xarray_t                         xarray_nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (lb.sof && lb.pix_valid) state_nxt = FILL;
      FILL:       if (accept && last_pix)     state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // sof with a pixel always restarts at (0,0); counters are bypassed so the
  // restart pixel addresses column 0 in the same cycle.
  always_comb begin
    restart  = lb.sof && lb.pix_valid;
    accept   = restart || (lb.pix_valid && state == FILL);
    drop     = lb.pix_valid && !accept;
    cur_col  = restart ? '0 : col;
    cur_row  = restart ? '0 : row;
    last_pix = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    win_hit  = accept && (cur_row >= ROW_V) && (cur_col >= COL_V);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_pix) begin
        col <= '0;
        row <= '0;
      end else if (cur_col == COL_LAST) begin
        col <= '0;
        row <= cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end

  // Line k holds the row k+1 above the current one.
  for (genvar k = 0; k < WIN_H-1; k++) begin : g_line
    pixel_t din;
    if (k == 0) begin : g_head
      assign din = lb.pix_in;
    end else begin : g_tail
      assign din = lout[k-1];
    end
    line_delay #(.IMG_W(IMG_W)) u_line (
      .clk  (clk),
      .en   (accept),
      .col  (cur_col),
      .din  (din),
      .dout (lout[k])
    );
  end

  always_comb begin
    newcol     = '0;
    win_nxt    = '0;
    xarray_nxt = '0;
    newcol[WIN_H-1] = lb.pix_in;
    for (int r = 0; r < WIN_H-1; r++)
      newcol[r] = lout[WIN_H-2-r];
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W-1; c++)
        win_nxt[r][c] = win_q[r][c+1];
      win_nxt[r][WIN_W-1] = newcol[r];
    end
    for (int r = 0; r < WIN_H; r++)
      for (int c = 0; c < WIN_W; c++)
        xarray_nxt[1 + r*WIN_W + c] = win_nxt[r][c];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      win_q         <= '0;
      lb.xarray     <= '0;
      lb.win_valid  <= 1'b0;
      lb.win_x      <= '0;
      lb.win_y      <= '0;
      lb.frame_done <= 1'b0;
      lb.overflow   <= 1'b0;
    end else begin
      lb.win_valid  <= win_hit;
      lb.frame_done <= accept && last_pix;
      if (drop)   lb.overflow <= 1'b1;
      if (accept) win_q <= win_nxt;
      if (win_hit) begin
        lb.xarray <= xarray_nxt;
        lb.win_x  <= CRD_W'(cur_col - COL_V);
        lb.win_y  <= CRD_W'(cur_row - ROW_V);
      end
    end
endmodule
